// File: rtl/snes_responder_if.sv
// snes_responder_if: SNES controller wire bundle (host drives latch/clock, responder drives serial)
interface snes_responder_if;
  logic con_latch;
  logic con_clock;
  logic con_serial;
  modport master (output con_latch, output con_clock, input con_serial);
  modport slave (input con_latch, input con_clock, output con_serial);
endinterface

// File: rtl/snes_responder.sv
// snes_responder: SNES pad emulator; ports clk, rst_n (async low), con (latch/clock in, serial out), buttons[15:0], busy, frame_done
module snes_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  snes_responder_if.slave    con,
  input  logic [15:0]        buttons,
  output logic               busy,
  output logic               frame_done
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] latch_sync, clock_sync;
  logic latch_s, clock_s, latch_d, clock_d, clk_rise, latch_fall, done_nx;
  logic [15:0] shreg, shreg_nx;
  logic [4:0] idx, idx_nx;
  logic [TW-1:0] tmo, tmo_nx;
  assign latch_s = latch_sync[SYNC_STAGES-1];
  assign clock_s = clock_sync[SYNC_STAGES-1];
  assign clk_rise = clock_s & ~clock_d;
  assign latch_fall = ~latch_s & latch_d;
  assign busy = (state == LATCH) || (state == SHIFT);
  assign con.con_serial = (state == IDLE) ? 1'b1 : (state == DONE) ? 1'b0 : shreg[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync <= '0;
      clock_sync <= '1;
      latch_d <= 1'b0;
      clock_d <= 1'b1;
      state <= IDLE;
      shreg <= '1;
      idx <= '0;
      tmo <= '0;
      frame_done <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], con.con_latch};
      clock_sync <= {clock_sync[SYNC_STAGES-2:0], con.con_clock};
      latch_d <= latch_s;
      clock_d <= clock_s;
      state <= state_nx;
      shreg <= shreg_nx;
      idx <= idx_nx;
      tmo <= tmo_nx;
      frame_done <= done_nx;
    end
  end
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    idx_nx = idx;
    tmo_nx = '0;
    done_nx = 1'b0;
    if (latch_s) begin
      state_nx = LATCH;
      shreg_nx = ~buttons;
      idx_nx = '0;
    end else if (state == LATCH && latch_fall) begin
      state_nx = SHIFT;
      idx_nx = '0;
    end else if (state == SHIFT) begin
      if (clk_rise) begin
        shreg_nx = {1'b1, shreg[15:1]};
        idx_nx = idx + 5'd1;
        state_nx = (idx == 5'd15) ? DONE : SHIFT;
        done_nx = (idx == 5'd15);
      end else if (tmo == TMAX) begin
        state_nx = IDLE;
        shreg_nx = '1;
        idx_nx = '0;
        tmo_nx = tmo;
      end else begin
        tmo_nx = tmo + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_snes_responder.sv
// tb_snes_responder: directed scoreboard bench for snes_responder
module tb_snes_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] buttons = 16'h0000;
  logic busy, frame_done;
  int total = 0;
  int bad = 0;
  int fd_cnt = 0;
  logic exp_q[$];
  logic prev = 1'b1;
  snes_responder_if con();
  snes_responder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .con(con),
    .buttons(buttons),
    .busy(busy),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (frame_done === 1'b1) fd_cnt++;
  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_serial(string tag);
    logic e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty, observed=%0b", tag, con.con_serial);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 16'(con.con_serial), 16'(e));
      prev = e;
    end
  endtask
  task automatic shift_bit(int k, logic [15:0] b);
    con.con_clock = 1'b0;
    wait_n(4);
    exp_q.push_back(k == 15 ? 1'b0 : ~b[(k + 1) & 15]);
    con.con_clock = 1'b1;
    wait_n(2);
    chk("latency_hold", 16'(con.con_serial), 16'(prev));
    wait_n(1);
    check_serial("bit");
    if (k == 15) begin
      chk("done_pulse", 16'(frame_done), 16'd1);
      wait_n(1);
      chk("done_single", 16'(frame_done), 16'd0);
    end
  endtask
  task automatic frame(logic [15:0] b, int nclk);
    buttons = b;
    exp_q.push_back(~b[0]);
    con.con_latch = 1'b1;
    con.con_clock = 1'b1;
    wait_n(4);
    chk("latch_busy", 16'(busy), 16'd1);
    con.con_latch = 1'b0;
    wait_n(4);
    check_serial("bit0");
    chk("shift_busy", 16'(busy), 16'd1);
    for (int k = 0; k < nclk; k++) shift_bit(k, b);
  endtask
  initial begin
    con.con_latch = 1'b0;
    con.con_clock = 1'b1;
    wait_n(2);
    chk("rst_serial", 16'(con.con_serial), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(frame_done), 16'd0);
    rst_n = 1'b1;
    wait_n(3);
    frame(16'h0101, 16);
    chk("f1_fd", 16'(fd_cnt), 16'd1);
    con.con_clock = 1'b0;
    wait_n(4);
    con.con_clock = 1'b1;
    wait_n(4);
    chk("done_ignore_serial", 16'(con.con_serial), 16'd0);
    chk("done_ignore_busy", 16'(busy), 16'd0);
    chk("done_ignore_fd", 16'(fd_cnt), 16'd1);
    frame(16'h0000, 5);
    buttons = 16'hFFFF;
    for (int k = 5; k < 16; k++) shift_bit(k, 16'h0000);
    chk("hold_fd", 16'(fd_cnt), 16'd2);
    frame(16'h1234, 5);
    frame(16'h5A0F, 16);
    chk("restart_fd", 16'(fd_cnt), 16'd3);
    frame(16'h00FF, 3);
    wait_n(20);
    chk("tmo_busy", 16'(busy), 16'd0);
    chk("tmo_serial", 16'(con.con_serial), 16'd1);
    chk("tmo_fd", 16'(fd_cnt), 16'd3);
    frame(16'hC3A5, 4);
    con.con_clock = 1'b0;
    wait_n(4);
    frame(16'h6E91, 16);
    chk("collide_fd", 16'(fd_cnt), 16'd4);
    frame(16'h0F0F, 7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_serial", 16'(con.con_serial), 16'd1);
    chk("arst_busy", 16'(busy), 16'd0);
    wait_n(2);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      con.con_clock = 1'b0;
      wait_n(4);
      con.con_clock = 1'b1;
      wait_n(4);
      chk("post_rst_serial", 16'(con.con_serial), 16'd1);
      chk("post_rst_busy", 16'(busy), 16'd0);
    end
    chk("post_rst_fd", 16'(fd_cnt), 16'd4);
    frame(16'h8001, 16);
    chk("final_fd", 16'(fd_cnt), 16'd5);
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snes_responder.md
SNES_RESPONDER -- requirements
Module: snes_responder

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on con_latch and con_clock (legal range 2..4).
REQ-002 Parameter: TIMEOUT_CYCLES, default 4096, clk cycles without a con_clock rising edge before an open frame is abandoned.
REQ-003 Port: clk  input  1  system clock; the only clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: con_latch  input  1  latch from the external host; asynchronous to clk.
REQ-006 Port: con_clock  input  1  shift clock from the external host; asynchronous to clk; idles high.
REQ-007 Port: buttons  input  16  button state, active-high (1 = pressed); bit 0 = B, 1 = Y, 2 = Select, 3 = Start, 4..7 = Up/Down/Left/Right, 8 = A, 9 = X, 10 = L, 11 = R, 12..15 user-defined.
REQ-008 Port: con_serial  output  1  serial data to the host; active-low on the wire.
REQ-009 Port: busy  output  1  high while state is LATCH or SHIFT.
REQ-010 Port: frame_done  output  1  one-cycle pulse when the 16th bit has been consumed.

Function
REQ-011 con_latch and con_clock SHALL each pass through SYNC_STAGES flops; all logic SHALL use only the synchronized versions.
REQ-012 Rising and falling edges SHALL be detected by comparing the synchronized signal with a one-cycle-delayed copy.
REQ-013 The FSM SHALL have four states: IDLE, LATCH, SHIFT, DONE.
REQ-014 From any state, a synchronized latch level of 1 SHALL cause a transition to LATCH on the next clk; this includes latch asserted mid-shift, which restarts the frame.
REQ-015 In LATCH, the shift register SHALL reload ~buttons every cycle; con_clock edges SHALL be ignored.
REQ-016 On a synchronized latch falling edge, the FSM SHALL go LATCH -> SHIFT with bit index 0; the value captured on the last LATCH cycle is held.
REQ-017 con_serial SHALL equal the shift register LSB (~buttons[index]) in LATCH and SHIFT; bit 0 SHALL be visible before the first clock edge.
REQ-018 In SHIFT, each synchronized con_clock rising edge SHALL shift right by one and increment the 5-bit index.
REQ-019 On the 16th rising edge in SHIFT, the FSM SHALL enter DONE, con_serial SHALL drive 0, and frame_done SHALL pulse for exactly one cycle.
REQ-020 In DONE, further clock edges SHALL be ignored and con_serial SHALL stay 0 until the next latch.
REQ-021 In IDLE, con_serial SHALL be 1 (all released).
REQ-022 In SHIFT, a counter SHALL count cycles since the last rising edge or since SHIFT entry; on reaching TIMEOUT_CYCLES, the FSM SHALL go to IDLE without a frame_done pulse.
REQ-023 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1) and SHALL saturate, never wrap.
REQ-024 Latency: a wire edge SHALL affect con_serial exactly SYNC_STAGES+1 clk cycles later.
REQ-025 A latch rising edge and a clock rising edge in the same cycle SHALL resolve as latch; no shift occurs.

Reset
REQ-026 While rst_n = 0, the block SHALL hold: state IDLE, con_serial 1, busy 0, frame_done 0, index 0, shift register 16'hFFFF, timeout counter 0, synchronizer flops latch = 0 and clock = 1.
REQ-027 Reset deassertion mid-frame SHALL discard the frame; the next activity honored is a latch.

Verification
REQ-028 buttons = 16'h0101, latch pulse, 16 clock pulses -> con_serial sequence 0,1,1,1,1,1,1,1,0,1,1,1,1,1,1,1, then 0; one frame_done.
REQ-029 buttons change 16'h0000 -> 16'hFFFF during SHIFT -> remaining bits still reflect 16'h0000 (all 1 on the wire).
REQ-030 Latch reasserted after 5 clocks, then 16 clocks -> frame restarts at bit 0; exactly one frame_done, at the end.
REQ-031 TIMEOUT_CYCLES = 16, latch, 3 clocks, then idle 20 cycles -> return to IDLE, con_serial 1, no frame_done.
REQ-032 Each clock edge -> con_serial changes exactly 3 clk cycles after the wire edge (SYNC_STAGES = 2).
REQ-033 rst_n pulsed low at bit 7 -> con_serial 1 and busy 0 immediately; clocks before the next latch are ignored.
